// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the tri-state memory bus arbiter.
// State encoding, default dead-cycle count and the owner-index width helper.
package mem_bus_pkg;

    // Arbiter phases: no owner, dead cycles before a grant, bus owned
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_TURN = 2'd1,
        ARB_OWN  = 2'd2
    } arb_state_t;

    // Dead cycles with every buffer disabled before any new owner drives
    localparam int DEF_TURNAROUND = 1;

    // Owner index width; a single requester still gets a 1-bit index
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr,
// searching circularly. o_winner is meaningless when o_any_req is low.
module rr_pick
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_req
);

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    int                 w_pos;
    int                 w_sum;

    assign o_any_req = |i_req;

    // Rotate requests so the priority pointer lands on bit 0, take the first
    // set bit, then map the rotated position back to an absolute index
    always_comb begin
        w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[0]) begin
                w_found = 1'b1;
                w_pos   = k;
            end
            w_rot = w_rot >> 1;
        end
        w_sum = int'(i_ptr) + w_pos;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        o_winner = IDX_W'(w_sum);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state memory data bus.
// Produces one-hot buffer enables with TURNAROUND dead cycles before every
// grant. Optional ownership time limit: define MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TURNAROUND = DEF_TURNAROUND,
    parameter int MAX_HOLD   = 16,
    parameter int IDX_W      = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] drive_en,
    output logic [IDX_W-1:0]   owner,
    output logic               busy,
    output logic [NUM_REQ-1:0] timeout
);

    localparam int              CNT_W     = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURNAROUND - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam bit              PARAMS_OK = (NUM_REQ >= 1) && (TURNAROUND >= 1) && (MAX_HOLD >= 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;

    logic [NUM_REQ-1:0] w_owner_oh;
    logic [NUM_REQ-1:0] w_others;
    logic               w_own_req;
    logic               w_own_done;
    logic               w_forced;
    logic               w_release;
    logic [IDX_W-1:0]   w_ptr_adv;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [IDX_W-1:0]   w_winner;
    logic               w_any_req;

    // Owner-relative views of the request/done vectors
    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    assign w_own_req  = |(req & w_owner_oh);
    assign w_own_done = |(done & w_owner_oh);
    assign w_others   = req & ~w_owner_oh;
    assign w_release  = w_own_done | ~w_own_req | w_forced;

    // Pointer after a release: one past the owner, wrapping to 0
    assign w_ptr_adv  = (r_owner == LAST_IDX) ? '0 : r_owner + IDX_W'(1);

    // While owning, the next winner must come from the advanced pointer so the
    // releasing owner drops to lowest priority in the same cycle
    assign w_pick_ptr = (r_state == ARB_OWN) ? w_ptr_adv : r_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req     (req),
        .i_ptr     (w_pick_ptr),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    // Arbitration state register and its registered side data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Next-state decode: grant is raised on OWN entry and dropped on the same
    // edge that samples the release, so enables are never on during TURN
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ARB_TURN;
                    w_owner_nxt = w_winner;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            ARB_TURN: begin
                if (r_cnt == '0) begin
                    if (w_own_req) begin
                        w_state_nxt = ARB_OWN;
                        w_grant_nxt = w_owner_oh;
                    end else begin
                        // Request withdrawn during dead time: no grant, ptr kept
                        w_state_nxt = ARB_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ARB_OWN: begin
                if (w_release) begin
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_adv;
                    if (|w_others) begin
                        w_state_nxt = ARB_TURN;
                        w_owner_nxt = w_winner;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int               HOLD_W   = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0]  r_hold;
    logic [NUM_REQ-1:0] r_timeout;

    assign w_forced = (r_state == ARB_OWN) && (r_hold == HOLD_LIM);

    // Cycles spent owning; zero outside OWN so every ownership starts at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state == ARB_OWN && !w_release) begin
            r_hold <= r_hold + HOLD_W'(1);
        end else begin
            r_hold <= '0;
        end
    end

    // One-cycle pulse aligned with the grant drop, only when the limit alone
    // caused the release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= '0;
        end else if (w_forced && w_own_req && !w_own_done) begin
            r_timeout <= w_owner_oh;
        end else begin
            r_timeout <= '0;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_forced = 1'b0;
    assign timeout  = '0;
`endif

    assign grant    = r_grant;
    // Buffers must go quiet the instant reset is seen, not at the next edge
    assign drive_en = rst ? '0 : r_grant;
    assign owner    = r_owner;
    assign busy     = (r_state != ARB_IDLE);

    // Bus contention guards
    a_params_ok: assert property (@(posedge clk) PARAMS_OK);
    a_onehot:    assert property (@(posedge clk) disable iff (rst) $onehot0(drive_en));
    a_turn_dead: assert property (@(posedge clk) disable iff (rst)
                                  (r_state == ARB_TURN) |-> (drive_en == '0));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed sequences with literal checks plus a
// per-cycle comparison against a queue-free behavioural arbitration model.
module tb_mem_bus_arbiter;

    localparam int N  = 4;
    localparam int T  = 1;
    localparam int MH = 16;
    localparam int IW = 2;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  done = '0;
    logic [N-1:0]  grant;
    logic [N-1:0]  drive_en;
    logic [IW-1:0] owner;
    logic          busy;
    logic [N-1:0]  timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NUM_REQ    (N),
        .TURNAROUND (T),
        .MAX_HOLD   (MH),
        .IDX_W      (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .drive_en (drive_en),
        .owner    (owner),
        .busy     (busy),
        .timeout  (timeout)
    );

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (bit_of(r, (start + k) % N)) return (start + k) % N;
        end
        return -1;
    endfunction

    // Model: who owns the bus (-1 none), dead cycles left before candidate
    int           m_own, m_dead, m_cand, m_ptr, m_last, m_hold;
    logic [N-1:0] m_to;
    logic [N-1:0] m_others;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_own = -1; m_dead = 0; m_cand = 0; m_ptr = 0; m_last = 0; m_hold = 0; m_to = '0;
        end else begin
            m_to = '0;
            if (m_dead > 0) begin
                m_dead--;
                if (m_dead == 0 && bit_of(req, m_cand)) begin
                    m_own = m_cand; m_hold = 0;
                end
            end else if (m_own >= 0) begin
                if (bit_of(done, m_own) || !bit_of(req, m_own) || (TO_EN && m_hold == MH - 1)) begin
                    if (TO_EN && m_hold == MH - 1 && !bit_of(done, m_own) && bit_of(req, m_own))
                        m_to = N'(1) << m_own;
                    m_others = req & ~(N'(1) << m_own);
                    m_ptr = (m_own + 1) % N;
                    m_own = -1;
                    if (m_others != 0) begin
                        m_cand = pick(req, m_ptr); m_dead = T; m_last = m_cand;
                    end
                end else begin
                    m_hold++;
                end
            end else if (req != 0) begin
                m_cand = pick(req, m_ptr); m_dead = T; m_last = m_cand;
            end
        end
    end

    // Per-cycle comparison against the model
    logic [N-1:0] e_grant;
    always @(negedge clk) begin
        if (!rst) begin
            e_grant = (m_own >= 0) ? (N'(1) << m_own) : '0;
            tests++;
            if (grant !== e_grant || drive_en !== e_grant || int'(owner) != m_last ||
                busy !== (m_own >= 0 || m_dead > 0) || timeout !== m_to || !$onehot0(drive_en)) begin
                fails++;
                $display("FAIL cycle@%0t grant=%b exp %b drive_en=%b owner=%0d exp %0d busy=%b timeout=%b exp %b",
                         $time, grant, e_grant, drive_en, owner, m_last, busy, timeout, m_to);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge with a grant
    task automatic wait_grant(output int zeros);
        zeros = 0;
        while (grant == '0 && zeros < 30) begin
            zeros++;
            @(negedge clk);
        end
        if (grant == '0) begin
            tests++; fails++;
            $display("FAIL wait_grant no grant within 30 cycles");
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int zeros;
    int cnt;

    initial begin
        // reset held for 5 cycles with no requests
        repeat (5) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_drive_en", 32'(drive_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single requester: TURN then grant, release with done
        req = 4'b0100;
        @(negedge clk); check("pre_sample_busy", 32'(busy), 0);
        @(negedge clk);
        check("turn_busy", 32'(busy), 1);
        check("turn_grant", 32'(grant), 0);
        check("turn_owner", 32'(owner), 2);
        @(negedge clk); check("own_grant", 32'(grant), 32'b0100);
        @(negedge clk); check("own_grant2", 32'(drive_en), 32'b0100);
        done = 4'b0100; req = '0;
        @(negedge clk);
        check("rel_grant", 32'(grant), 0);
        check("rel_idle", 32'(busy), 0);
        done = '0;

        // withdrawn request during dead time: no grant issued
        req = 4'b1000;
        @(negedge clk);
        check("wd_busy", 32'(busy), 1);
        check("wd_owner", 32'(owner), 3);
        req = '0;
        @(negedge clk);
        check("wd_idle", 32'(busy), 0);
        check("wd_nogrant", 32'(grant), 0);

        // all requesting, each owner releases after 2 cycles
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(zeros);
            check("rr_order", 32'(grant), 32'(1) << exp_order[n]);
            if (n > 0) check("rr_gap", 32'(zeros), 1);
            @(negedge clk); done = grant;
            @(negedge clk); done = '0;
        end
        req = '0;

        // wrap of the pointer and non-owner done ignored
        do_reset();
        req = 4'b0011;
        @(negedge clk);
        wait_grant(zeros);
        check("own0_first", 32'(grant), 32'b0001);
        @(negedge clk); done = 4'b1000;
        @(negedge clk); done = '0;
        check("ignore_done3", 32'(grant), 32'b0001);
        done = 4'b0001;
        @(negedge clk); done = '0;
        check("rel0_dead", 32'(grant), 0);
        wait_grant(zeros);
        check("own1", 32'(grant), 32'b0010);
        done = 4'b0010;
        @(negedge clk); done = '0;
        wait_grant(zeros);
        check("wrap_to0", 32'(grant), 32'b0001);
        check("wrap_owner", 32'(owner), 0);
        req = '0;

        // asynchronous reset while requester 1 owns the bus
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        wait_grant(zeros);
        check("pre_rst_grant", 32'(grant), 32'b0010);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_drive_en", 32'(drive_en), 0);
        check("async_grant", 32'(grant), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("regrant_turn", 32'(grant), 0);
        check("regrant_busy", 32'(busy), 1);
        @(negedge clk);
        check("regrant", 32'(grant), 32'b0010);
        req = '0;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // forced release after MAX_HOLD owning cycles
        do_reset();
        req = 4'b0011;
        @(negedge clk);
        wait_grant(zeros);
        cnt = 0;
        while (grant == 4'b0001 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("to_hold_cycles", 32'(cnt), MH);
        check("to_pulse", 32'(timeout), 32'b0001);
        @(negedge clk);
        check("to_pulse_end", 32'(timeout), 0);
        check("to_next_owner", 32'(grant), 32'b0010);
        req = '0;
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
